// File: rtl/frame_fifo_to_axis_packer.sv
// Frame FIFO to AXI-Stream packer.
// Packs PIXELS_PER_BEAT first-word-fall-through FIFO words into one registered
// AXIS beat. The packer locks onto start-of-frame and starts or stops only at
// line boundaries. A partial beat is flushed with tkeep. The block also flags
// early SOF and keeps status counters.
module frame_fifo_to_axis_packer #(
  parameter int FIFO_DATA_WIDTH   = 16,
  parameter int PIXELS_PER_BEAT   = 2,
  parameter int AXIS_DATA_WIDTH   = FIFO_DATA_WIDTH * PIXELS_PER_BEAT,
  parameter int AXIS_STROBE_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int USER_DEPTH        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_enable,
  input  logic                         i_clear_errors,
  input  logic                         i_frame_fifo_ready,
  output logic                         o_frame_fifo_next_stb,
  input  logic                         i_frame_fifo_sof,
  input  logic                         i_frame_fifo_last,
  input  logic [FIFO_DATA_WIDTH-1:0]   i_frame_fifo_data,
  output logic [USER_DEPTH-1:0]        o_axis_user,
  input  logic                         i_axis_ready,
  output logic [AXIS_DATA_WIDTH-1:0]   o_axis_data,
  output logic [AXIS_STROBE_WIDTH-1:0] o_axis_keep,
  output logic                         o_axis_last,
  output logic                         o_axis_valid,
  output logic                         o_busy,
  output logic                         o_sof_error,
  output logic [15:0]                  o_drop_count,
  output logic [15:0]                  o_line_count,
  output logic [31:0]                  o_frame_count
);

  localparam int LANE_KEEP = FIFO_DATA_WIDTH / 8;
  localparam int CNT_W     = $clog2(PIXELS_PER_BEAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STREAM
  } state_e;

  state_e                       state_q;
  logic                         stop_q;      // enable dropped; finish the current line
  logic                         final_q;     // the closed beat is the last one before IDLE

  // Accumulator being filled from the FIFO
  logic [AXIS_DATA_WIDTH-1:0]   acc_data_q;
  logic [AXIS_STROBE_WIDTH-1:0] acc_keep_q;
  logic [CNT_W-1:0]             acc_cnt_q;
  logic                         acc_closed_q;
  logic                         acc_user_q;
  logic                         acc_last_q;

  // Output register presented on AXIS
  logic [AXIS_DATA_WIDTH-1:0]   axis_data_q;
  logic [AXIS_STROBE_WIDTH-1:0] axis_keep_q;
  logic                         axis_user_q;
  logic                         axis_last_q;
  logic                         axis_valid_q;

  logic                         sof_error_q;
  logic [15:0]                  drop_q;
  logic [15:0]                  line_q;
  logic [31:0]                  frame_q;

  logic                         acc_xfer;
  logic                         acc_open;
  logic [CNT_W-1:0]             eff_cnt;
  logic                         early_sof;
  logic                         pop_stream;
  logic                         pop_sync;
  logic                         word_closes;
  logic                         word_final;

  // Pop, transfer and close decisions for the current cycle
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block leaves a latch behind.
    acc_xfer    = 1'b0;
    acc_open    = 1'b0;
    eff_cnt     = '0;
    early_sof   = 1'b0;
    pop_stream  = 1'b0;
    pop_sync    = 1'b0;
    word_closes = 1'b0;
    word_final  = 1'b0;

    acc_xfer = acc_closed_q & (~axis_valid_q | i_axis_ready);
    acc_open = ~acc_closed_q | acc_xfer;
    // A beat that is moving out this cycle frees all lanes for the incoming word
    eff_cnt  = acc_xfer ? '0 : acc_cnt_q;

    if (state_q == ST_STREAM && i_frame_fifo_ready && acc_open && !final_q) begin
      if (i_frame_fifo_sof && eff_cnt != '0) begin
        early_sof = 1'b1;
      end else begin
        pop_stream = 1'b1;
      end
    end

    pop_sync = (state_q == ST_SYNC) & i_enable & i_frame_fifo_ready & ~i_frame_fifo_sof;

    word_closes = pop_stream &
                  ((eff_cnt + CNT_W'(1) == CNT_W'(PIXELS_PER_BEAT)) | i_frame_fifo_last);
    word_final  = pop_stream & i_frame_fifo_last & (stop_q | ~i_enable);
  end

  assign o_frame_fifo_next_stb = pop_stream | pop_sync;

  // FSM, accumulator, output register and status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator data is reset as well, because a beat caught mid-fill is thrown away and the lanes must read back as zero.
      state_q      <= ST_IDLE;
      stop_q       <= 1'b0;
      final_q      <= 1'b0;
      acc_data_q   <= '0;
      acc_keep_q   <= '0;
      acc_cnt_q    <= '0;
      acc_closed_q <= 1'b0;
      acc_user_q   <= 1'b0;
      acc_last_q   <= 1'b0;
      axis_data_q  <= '0;
      axis_keep_q  <= '0;
      axis_user_q  <= 1'b0;
      axis_last_q  <= 1'b0;
      axis_valid_q <= 1'b0;
      sof_error_q  <= 1'b0;
      drop_q       <= '0;
      line_q       <= '0;
      frame_q      <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment, so every statement sees the values from before the edge.
      // Output register: load a closed beat, or retire an accepted one
      if (acc_xfer) begin
        axis_data_q  <= acc_data_q;
        axis_keep_q  <= acc_keep_q;
        axis_user_q  <= acc_user_q;
        axis_last_q  <= acc_last_q;
        axis_valid_q <= 1'b1;
      end else if (i_axis_ready) begin
        axis_valid_q <= 1'b0;
      end

      // Frame and line counters advance on an accepted beat
      if (axis_valid_q && i_axis_ready) begin
        if (axis_user_q) begin
          frame_q <= frame_q + 32'd1;
          line_q  <= axis_last_q ? 16'd1 : 16'd0;
        end else if (axis_last_q) begin
          line_q  <= line_q + 16'd1;
        end
      end

      // Sticky SOF error; a new error wins over a clear
      if (early_sof) begin
        sof_error_q <= 1'b1;
      end else if (i_clear_errors) begin
        sof_error_q <= 1'b0;
      end

      // Accumulator: empty it on transfer, then optionally fill the next lane
      if (acc_xfer) begin
        acc_data_q   <= '0;
        acc_keep_q   <= '0;
        acc_cnt_q    <= '0;
        acc_closed_q <= 1'b0;
        acc_user_q   <= 1'b0;
        acc_last_q   <= 1'b0;
        final_q      <= 1'b0;
      end
      if (pop_stream) begin
        for (int l = 0; l < PIXELS_PER_BEAT; l++) begin
          if (eff_cnt == CNT_W'(l)) begin
            acc_data_q[l*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= i_frame_fifo_data;
            acc_keep_q[l*LANE_KEEP +: LANE_KEEP]             <= '1;
          end
        end
        acc_cnt_q    <= eff_cnt + CNT_W'(1);
        acc_closed_q <= word_closes;
        acc_last_q   <= i_frame_fifo_last;
        final_q      <= word_final;
        if (eff_cnt == '0) begin
          acc_user_q <= i_frame_fifo_sof;
        end
      end
      if (early_sof) begin
        acc_closed_q <= 1'b1;
        acc_last_q   <= 1'b1;
      end

      // Control FSM
      case (state_q)
        ST_IDLE: begin
          stop_q <= 1'b0;
          if (i_enable) state_q <= ST_SYNC;
        end
        ST_SYNC: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
          end else if (pop_sync) begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
          end else if (i_frame_fifo_ready) begin
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!i_enable) stop_q <= 1'b1;
          if (acc_xfer && final_q) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_axis_data   = axis_data_q;
  assign o_axis_keep   = axis_keep_q;
  assign o_axis_user   = USER_DEPTH'(axis_user_q);
  assign o_axis_last   = axis_last_q;
  assign o_axis_valid  = axis_valid_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_sof_error   = sof_error_q;
  assign o_drop_count  = drop_q;
  assign o_line_count  = line_q;
  assign o_frame_count = frame_q;

endmodule

// File: tb/tb_frame_fifo_to_axis_packer.sv
// Testbench for frame_fifo_to_axis_packer (PPB=2, 16-bit pixels).
// A FIFO model feeds words. Expected beats go into a scoreboard queue, and a
// monitor compares every accepted beat with that queue.
module tb_frame_fifo_to_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_clear_errors = 1'b0;
  logic        i_frame_fifo_ready = 1'b0;
  logic        o_frame_fifo_next_stb;
  logic        i_frame_fifo_sof = 1'b0;
  logic        i_frame_fifo_last = 1'b0;
  logic [15:0] i_frame_fifo_data = '0;
  logic [0:0]  o_axis_user;
  logic        i_axis_ready = 1'b1;
  logic [31:0] o_axis_data;
  logic [3:0]  o_axis_keep;
  logic        o_axis_last;
  logic        o_axis_valid;
  logic        o_busy;
  logic        o_sof_error;
  logic [15:0] o_drop_count;
  logic [15:0] o_line_count;
  logic [31:0] o_frame_count;

  frame_fifo_to_axis_packer #(
    .FIFO_DATA_WIDTH(16),
    .PIXELS_PER_BEAT(2),
    .USER_DEPTH(1)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_enable             (i_enable),
    .i_clear_errors       (i_clear_errors),
    .i_frame_fifo_ready   (i_frame_fifo_ready),
    .o_frame_fifo_next_stb(o_frame_fifo_next_stb),
    .i_frame_fifo_sof     (i_frame_fifo_sof),
    .i_frame_fifo_last    (i_frame_fifo_last),
    .i_frame_fifo_data    (i_frame_fifo_data),
    .o_axis_user          (o_axis_user),
    .i_axis_ready         (i_axis_ready),
    .o_axis_data          (o_axis_data),
    .o_axis_keep          (o_axis_keep),
    .o_axis_last          (o_axis_last),
    .o_axis_valid         (o_axis_valid),
    .o_busy               (o_busy),
    .o_sof_error          (o_sof_error),
    .o_drop_count         (o_drop_count),
    .o_line_count         (o_line_count),
    .o_frame_count        (o_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sof;
    logic        last;
    logic [15:0] data;
  } word_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  word_t fifo_q[$];
  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  pop_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_fifo();
    i_frame_fifo_ready = (fifo_q.size() > 0);
    if (fifo_q.size() > 0) begin
      i_frame_fifo_sof  = fifo_q[0].sof;
      i_frame_fifo_last = fifo_q[0].last;
      i_frame_fifo_data = fifo_q[0].data;
    end else begin
      i_frame_fifo_sof  = 1'b0;
      i_frame_fifo_last = 1'b0;
      i_frame_fifo_data = '0;
    end
  endtask

  task automatic push_word(input logic sof, input logic last, input logic [15:0] data);
    word_t w;
    w.sof = sof; w.last = last; w.data = data;
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic expect_beat(input logic [31:0] data, input logic [3:0] keep, input logic last, input logic user);
    beat_t b;
    b.data = data; b.keep = keep; b.last = last; b.user = user;
    sb_q.push_back(b);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until all words are consumed and all expected beats seen
  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || o_axis_valid) && n < max_cycles) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL %s timeout: %0d beats and %0d words outstanding, required 0", name, sb_q.size(), fifo_q.size());
      sb_q.delete();
    end
    tick(2);
  endtask

  // FIFO model: sample the pop strobe mid-cycle, retire the word after the edge
  initial begin
    forever begin
      @(negedge clk);
      pop_seen = o_frame_fifo_next_stb;
      @(posedge clk);
      #1;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_seen = 1'b0;
      drive_fifo();
    end
  end

  // Monitor: compare accepted beats and check that stalled beats stay stable
  initial begin
    beat_t exp_b;
    logic        hold_v = 1'b0;
    logic [31:0] hold_data = '0;
    logic [3:0]  hold_keep = '0;
    logic        hold_last = 1'b0;
    logic        hold_user = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v) begin
        checks++;
        if (!(o_axis_valid && o_axis_data == hold_data && o_axis_keep == hold_keep &&
              o_axis_last == hold_last && o_axis_user[0] == hold_user)) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%0h k=%0h l=%0b u=%0b expected v=1 d=%0h k=%0h l=%0b u=%0b",
                   o_axis_valid, o_axis_data, o_axis_keep, o_axis_last, o_axis_user[0],
                   hold_data, hold_keep, hold_last, hold_user);
        end
      end
      if (o_axis_valid && i_axis_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got d=%0h k=%0h l=%0b u=%0b expected no beat",
                   o_axis_data, o_axis_keep, o_axis_last, o_axis_user[0]);
        end else begin
          exp_b = sb_q.pop_front();
          if (o_axis_data !== exp_b.data || o_axis_keep !== exp_b.keep ||
              o_axis_last !== exp_b.last || o_axis_user[0] !== exp_b.user) begin
            errors++;
            $display("FAIL beat: got d=%0h k=%0h l=%0b u=%0b expected d=%0h k=%0h l=%0b u=%0b",
                     o_axis_data, o_axis_keep, o_axis_last, o_axis_user[0],
                     exp_b.data, exp_b.keep, exp_b.last, exp_b.user);
          end
        end
      end
      hold_v    = o_axis_valid && !i_axis_ready;
      hold_data = o_axis_data;
      hold_keep = o_axis_keep;
      hold_last = o_axis_last;
      hold_user = o_axis_user[0];
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int n;
    tick(3);
    check("reset_valid", o_axis_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_frame_count", o_frame_count, 0);
    check("reset_next_stb", o_frame_fifo_next_stb, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", o_busy, 0);

    // 1: one full line of 4 words starting a frame
    i_enable = 1'b1;
    push_word(1'b1, 1'b0, 16'hA000);
    push_word(1'b0, 1'b0, 16'hA001);
    push_word(1'b0, 1'b0, 16'hA002);
    push_word(1'b0, 1'b1, 16'hA003);
    expect_beat(32'hA001_A000, 4'hF, 1'b0, 1'b1);
    expect_beat(32'hA003_A002, 4'hF, 1'b1, 1'b0);
    wait_drain("t1", 100);
    check("t1_frame_count", o_frame_count, 1);
    check("t1_line_count", o_line_count, 1);
    check("t1_drop_count", o_drop_count, 0);

    // 2: odd-length line flushes a partial beat
    push_word(1'b0, 1'b0, 16'hB000);
    push_word(1'b0, 1'b0, 16'hB001);
    push_word(1'b0, 1'b1, 16'hB002);
    expect_beat(32'hB001_B000, 4'hF, 1'b0, 1'b0);
    expect_beat(32'h0000_B002, 4'h3, 1'b1, 1'b0);
    wait_drain("t2", 100);
    check("t2_line_count", o_line_count, 2);

    // 3: downstream stall mid-line
    i_axis_ready = 1'b0;
    push_word(1'b0, 1'b0, 16'hC000);
    push_word(1'b0, 1'b0, 16'hC001);
    push_word(1'b0, 1'b0, 16'hC002);
    push_word(1'b0, 1'b0, 16'hC003);
    push_word(1'b0, 1'b0, 16'hC004);
    push_word(1'b0, 1'b1, 16'hC005);
    expect_beat(32'hC001_C000, 4'hF, 1'b0, 1'b0);
    expect_beat(32'hC003_C002, 4'hF, 1'b0, 1'b0);
    expect_beat(32'hC005_C004, 4'hF, 1'b1, 1'b0);
    tick(10);
    check("t3_valid_held", o_axis_valid, 1);
    check("t3_words_left", fifo_q.size(), 2);
    check("t3_no_pop", o_frame_fifo_next_stb, 0);
    i_axis_ready = 1'b1;
    wait_drain("t3", 100);
    check("t3_line_count", o_line_count, 3);

    // Stop request mid-line: line completes, then IDLE
    push_word(1'b0, 1'b0, 16'hD000);
    push_word(1'b0, 1'b0, 16'hD001);
    push_word(1'b0, 1'b0, 16'hD002);
    push_word(1'b0, 1'b1, 16'hD003);
    i_enable = 1'b0;
    expect_beat(32'hD001_D000, 4'hF, 1'b0, 1'b0);
    expect_beat(32'hD003_D002, 4'hF, 1'b1, 1'b0);
    wait_drain("stop", 100);
    check("stop_busy", o_busy, 0);
    check("stop_line_count", o_line_count, 4);

    // 4: idle ignores words, then SYNC drops non-SOF words
    push_word(1'b0, 1'b0, 16'hE000);
    push_word(1'b0, 1'b0, 16'hE001);
    push_word(1'b0, 1'b1, 16'hE002);
    tick(5);
    check("idle_no_pop", fifo_q.size(), 3);
    push_word(1'b1, 1'b0, 16'hF000);
    push_word(1'b0, 1'b1, 16'hF001);
    expect_beat(32'hF001_F000, 4'hF, 1'b1, 1'b1);
    i_enable = 1'b1;
    wait_drain("t4", 100);
    check("t4_drop_count", o_drop_count, 3);
    check("t4_frame_count", o_frame_count, 2);
    check("t4_line_count", o_line_count, 1);
    check("t4_sof_error", o_sof_error, 0);

    // 5: SOF arrives after one word of a beat
    push_word(1'b0, 1'b0, 16'h1111);
    push_word(1'b1, 1'b0, 16'h2222);
    push_word(1'b0, 1'b1, 16'h3333);
    expect_beat(32'h0000_1111, 4'h3, 1'b1, 1'b0);
    expect_beat(32'h3333_2222, 4'hF, 1'b1, 1'b1);
    wait_drain("t5", 100);
    check("t5_sof_error", o_sof_error, 1);
    check("t5_frame_count", o_frame_count, 3);
    check("t5_line_count", o_line_count, 1);
    i_clear_errors = 1'b1;
    tick(1);
    i_clear_errors = 1'b0;
    check("t5_sof_error_cleared", o_sof_error, 0);

    // 6: async reset while a beat is held on the output
    i_axis_ready = 1'b0;
    push_word(1'b0, 1'b0, 16'h4444);
    push_word(1'b0, 1'b1, 16'h5555);
    n = 0;
    while (!o_axis_valid && n < 50) begin
      tick(1);
      n++;
    end
    check("t6_valid_before_reset", o_axis_valid, 1);
    i_enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_reset_valid", o_axis_valid, 0);
    check("t6_reset_data", o_axis_data, 0);
    check("t6_reset_frame_count", o_frame_count, 0);
    check("t6_reset_busy", o_busy, 0);
    fifo_q.delete();
    drive_fifo();
    i_axis_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    push_word(1'b0, 1'b0, 16'h6666);
    tick(5);
    check("t6_idle_after_reset", o_busy, 0);
    check("t6_idle_no_pop", fifo_q.size(), 1);
    i_enable = 1'b1;
    tick(2);
    check("t6_busy_after_enable", o_busy, 1);
    i_enable = 1'b0;
    tick(3);
    check("t6_drop_in_sync", o_drop_count, 1);
    check("t6_scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
